// File: rtl/rtc_pkg.sv
// Shared RTC field definitions: field index encodings, FSM state codes,
// per-field BCD masks and legal binary ranges.
// Purely declarative; no clocked logic and no flow control of its own.
//
// Contents:
//   NUM_FIELDS          number of bytes in one RTC frame
//   FLD_*               field index encodings, in RTC transmit order
//   ST_*                state codes of the frame receiver
//   field_mask()        bits of the raw byte that carry BCD digits
//   field_min/max()     legal binary range of each field
package rtc_pkg;

  localparam int NUM_FIELDS = 7;

  // Field index encodings, in the order the RTC shifts them out.
  localparam logic [2:0] FLD_SEC   = 3'd0;
  localparam logic [2:0] FLD_MIN   = 3'd1;
  localparam logic [2:0] FLD_HOUR  = 3'd2;
  localparam logic [2:0] FLD_DAY   = 3'd3;
  localparam logic [2:0] FLD_DATE  = 3'd4;
  localparam logic [2:0] FLD_MONTH = 3'd5;
  localparam logic [2:0] FLD_YEAR  = 3'd6;

  // Receiver states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bit 6 of the raw hours byte selects 12-hour mode on the RTC; this
  // block only understands 24-hour time.
  localparam int HOUR_12H_BIT = 6;

  // Bit 7 of the raw month byte is the century flag.
  localparam int MONTH_CENTURY_BIT = 7;

  // Strips control/flag bits (clock-halt, 12/24 mode, century) so only the
  // BCD digits reach the converter.
  function automatic logic [7:0] field_mask(input logic [2:0] idx);
    logic [7:0] m;
    case (idx)
      FLD_SEC:   m = 8'h7F;
      FLD_MIN:   m = 8'h7F;
      FLD_HOUR:  m = 8'h3F;
      FLD_DAY:   m = 8'h07;
      FLD_DATE:  m = 8'h3F;
      FLD_MONTH: m = 8'h1F;
      FLD_YEAR:  m = 8'hFF;
      default:   m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic [6:0] field_min(input logic [2:0] idx);
    logic [6:0] v;
    case (idx)
      FLD_DAY:   v = 7'd1;
      FLD_DATE:  v = 7'd1;
      FLD_MONTH: v = 7'd1;
      default:   v = 7'd0;
    endcase
    return v;
  endfunction

  function automatic logic [6:0] field_max(input logic [2:0] idx);
    logic [6:0] v;
    case (idx)
      FLD_SEC:   v = 7'd59;
      FLD_MIN:   v = 7'd59;
      FLD_HOUR:  v = 7'd23;
      FLD_DAY:   v = 7'd7;
      FLD_DATE:  v = 7'd31;
      FLD_MONTH: v = 7'd12;
      FLD_YEAR:  v = 7'd99;
      default:   v = 7'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/bcd2bin_byte.sv
// Converts one packed-BCD byte (two digits) to a 7-bit binary value.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
//
// Ports:
//   bcd      in  8  packed BCD, tens digit in [7:4], units digit in [3:0]
//   bin      out 7  tens*10 + units (meaningless when invalid is set)
//   invalid  out 1  either digit is above 9
module bcd2bin_byte (
  input  logic [7:0] bcd,
  output logic [6:0] bin,
  output logic       invalid
);

  logic [6:0] tens;
  logic [6:0] units;

  assign tens  = {3'b000, bcd[7:4]};
  assign units = {3'b000, bcd[3:0]};

  // tens*10 built from two shifts so no multiplier is inferred; the sum is
  // kept at 7 bits, which holds every legal result (max 99).
  assign bin = (tens << 3) + (tens << 1) + units;

  assign invalid = (bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9);

endmodule

// File: rtl/bcd_rtc_unpack.sv
// Receives a 7-byte packed-BCD RTC frame and unpacks it into binary fields.
// Latency: each field register updates on its acceptance edge (visible next cycle); Done one cycle after the last byte.
// Backpressure: In_ready is high throughout RECV; the sender may stall with In_valid=0 indefinitely.
//
// Ports:
//   Clock, Reset            system clock; synchronous active-high reset
//   Start                   one-cycle request to receive a frame (ignored unless idle)
//   Dato_in/In_valid        packed-BCD byte stream: sec, min, hour, day, date, month, year
//   In_ready                byte accepted this cycle when In_valid is also high
//   Seg..Ao                 binary fields
//   Century                 bit 7 of the last accepted month byte
//   Busy / Done             receiving / one-cycle frame-complete pulse
//   Err_mask / Error        per-field error flags (invalid digit, out of range, 12h mode) / their OR
module bcd_rtc_unpack
  import rtc_pkg::*;
#(
  parameter bit HOLD_ON_ERROR = 1'b0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] Dato_in,
  input  logic       In_valid,
  output logic       In_ready,
  output logic [6:0] Seg,
  output logic [6:0] Min,
  output logic [6:0] Hora,
  output logic [6:0] Dia,
  output logic [6:0] Fecha,
  output logic [6:0] Mes,
  output logic [6:0] Ao,
  output logic       Century,
  output logic       Busy,
  output logic       Done,
  output logic [6:0] Err_mask,
  output logic       Error
);

  logic [1:0] state_q;
  logic [2:0] idx_q;
  logic [6:0] fld_q [NUM_FIELDS];
  logic       century_q;
  logic [6:0] err_q;

  // Single shared converter: the byte is masked for whichever field is
  // currently expected before it reaches the converter.
  logic [7:0] masked_byte;
  logic [6:0] conv_bin;
  logic       nib_bad;

  assign masked_byte = Dato_in & field_mask(idx_q);

  bcd2bin_byte u_bcd2bin (
    .bcd     (masked_byte),
    .bin     (conv_bin),
    .invalid (nib_bad)
  );

  logic accept;
  logic range_bad;
  logic mode_bad;
  logic fld_err;
  logic fld_wr_en;
  logic [6:0] fld_wr_val;

  assign accept = (state_q == ST_RECV) && In_valid;

  // Range is only meaningful once both digits are known to be decimal.
  assign range_bad = !nib_bad &&
                     ((conv_bin < field_min(idx_q)) || (conv_bin > field_max(idx_q)));

  // 12-hour mode is flagged from the raw byte, since the mask drops that bit.
  assign mode_bad = (idx_q == FLD_HOUR) && Dato_in[HOUR_12H_BIT];

  assign fld_err = nib_bad || range_bad || mode_bad;

  // An undecodable byte leaves a defined zero rather than a wrapped sum;
  // out-of-range and mode errors still record what the RTC sent.
  assign fld_wr_val = nib_bad ? 7'd0 : conv_bin;
  assign fld_wr_en  = !(fld_err && HOLD_ON_ERROR);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= 3'd0;
      century_q <= 1'b0;
      err_q     <= 7'd0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        fld_q[i] <= 7'd0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            state_q <= ST_RECV;
            idx_q   <= FLD_SEC;
            err_q   <= 7'd0;
          end
        end

        ST_RECV: begin
          if (accept) begin
            if (fld_wr_en) begin
              fld_q[idx_q] <= fld_wr_val;
            end
            if (fld_err) begin
              err_q[idx_q] <= 1'b1;
            end
            if (idx_q == FLD_MONTH) begin
              century_q <= Dato_in[MONTH_CENTURY_BIT];
            end
            // The index parks on the year field; the next Start rewinds it.
            if (idx_q == FLD_YEAR) begin
              state_q <= ST_DONE;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign In_ready = (state_q == ST_RECV);
  assign Busy     = (state_q == ST_RECV);
  assign Done     = (state_q == ST_DONE);

  assign Seg      = fld_q[FLD_SEC];
  assign Min      = fld_q[FLD_MIN];
  assign Hora     = fld_q[FLD_HOUR];
  assign Dia      = fld_q[FLD_DAY];
  assign Fecha    = fld_q[FLD_DATE];
  assign Mes      = fld_q[FLD_MONTH];
  assign Ao       = fld_q[FLD_YEAR];
  assign Century  = century_q;
  assign Err_mask = err_q;
  assign Error    = |err_q;

endmodule

// File: tb/tb_bcd_rtc_unpack.sv
module tb_bcd_rtc_unpack;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start;
  logic       In_valid;
  logic [7:0] Dato_in;

  // Index 0: HOLD_ON_ERROR=0 instance, index 1: HOLD_ON_ERROR=1 instance.
  logic [6:0] fo [2][7];
  logic [6:0] em [2];
  logic       cent [2];
  logic       busy [2];
  logic       done [2];
  logic       rdy  [2];
  logic       errf [2];

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [6:0] exp_f [2][7];
  logic [6:0] exp_err;
  logic       exp_cent;
  logic [7:0] frame [7];

  int mask_tab [7] = '{127, 127, 63, 7, 63, 31, 255};
  int min_tab  [7] = '{0, 0, 0, 1, 1, 1, 0};
  int max_tab  [7] = '{59, 59, 23, 7, 31, 12, 99};

  always #5 Clock = ~Clock;

  bcd_rtc_unpack #(.HOLD_ON_ERROR(1'b0)) dut0 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Dato_in(Dato_in),
    .In_valid(In_valid), .In_ready(rdy[0]),
    .Seg(fo[0][0]), .Min(fo[0][1]), .Hora(fo[0][2]), .Dia(fo[0][3]),
    .Fecha(fo[0][4]), .Mes(fo[0][5]), .Ao(fo[0][6]),
    .Century(cent[0]), .Busy(busy[0]), .Done(done[0]),
    .Err_mask(em[0]), .Error(errf[0])
  );

  bcd_rtc_unpack #(.HOLD_ON_ERROR(1'b1)) dut1 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Dato_in(Dato_in),
    .In_valid(In_valid), .In_ready(rdy[1]),
    .Seg(fo[1][0]), .Min(fo[1][1]), .Hora(fo[1][2]), .Dia(fo[1][3]),
    .Fecha(fo[1][4]), .Mes(fo[1][5]), .Ao(fo[1][6]),
    .Century(cent[1]), .Busy(busy[1]), .Done(done[1]),
    .Err_mask(em[1]), .Error(errf[1])
  );

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int f = 0; f < 7; f++) exp_f[d][f] = 7'd0;
    exp_err  = 7'd0;
    exp_cent = 1'b0;
  endtask

  task automatic model_byte(input int f, input logic [7:0] b);
    int  m, t, u, v;
    bit  bad_nib, bad;
    m       = int'(b) & mask_tab[f];
    t       = m / 16;
    u       = m % 16;
    bad_nib = (t > 9) || (u > 9);
    v       = t * 10 + u;
    bad     = bad_nib || (v < min_tab[f]) || (v > max_tab[f]) || (f == 2 && b[6]);
    if (bad) exp_err[f] = 1'b1;
    exp_f[0][f] = bad_nib ? 7'd0 : 7'(v);
    if (!bad) exp_f[1][f] = 7'(v);
    if (f == 5) exp_cent = b[7];
  endtask

  function automatic logic [7:0] rand_byte(input int f);
    int v;
    logic [7:0] b;
    if ($urandom_range(0, 3) == 0) begin
      b = 8'($urandom_range(0, 255));
    end else begin
      v = $urandom_range(0, max_tab[f] + 2);
      if (v > 99) v = 99;
      b = {4'(v / 10), 4'(v % 10)};
      if ($urandom_range(0, 4) == 0) b = b | (($urandom_range(0, 1) == 1) ? 8'h80 : 8'h40);
    end
    return b;
  endfunction

  // Drives one frame from 'frame'; returns on the falling edge just after
  // the last byte has been accepted.
  task automatic send_frame(input bit rnd_stall);
    int k;
    @(negedge Clock); Start = 1'b1;
    @(negedge Clock); Start = 1'b0;
    exp_err = 7'd0;
    for (int i = 0; i < 7; i++) begin
      if (rnd_stall) begin
        k = $urandom_range(0, 2);
        if (k > 0) begin
          In_valid = 1'b0;
          repeat (k) @(negedge Clock);
        end
      end
      Dato_in  = frame[i];
      In_valid = 1'b1;
      @(negedge Clock);
      model_byte(i, frame[i]);
    end
    In_valid = 1'b0;
  endtask

  task automatic load_frame(input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
    frame[0] = b0; frame[1] = b1; frame[2] = b2; frame[3] = b3;
    frame[4] = b4; frame[5] = b5; frame[6] = b6;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; In_valid = 1'b0; Dato_in = 8'h00;
    model_clear();
    repeat (3) @(negedge Clock);
    for (int d = 0; d < 2; d++) begin
      for (int f = 0; f < 7; f++) begin
        checks++;
        if (fo[d][f] !== 7'd0) begin
          failures++; $display("FAIL reset_field d%0d f%0d: got %0d want 0", d, f, fo[d][f]);
        end
      end
      checks++;
      if ({em[d], cent[d], busy[d], done[d], rdy[d], errf[d]} !== 12'd0) begin
        failures++;
        $display("FAIL reset_ctrl d%0d: err=%b cent=%b busy=%b done=%b rdy=%b error=%b want all 0",
                 d, em[d], cent[d], busy[d], done[d], rdy[d], errf[d]);
      end
    end
    // Reset coinciding with Start wins.
    Start = 1'b1;
    @(negedge Clock); Start = 1'b0; Reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy[d] !== 1'b0) begin
        failures++; $display("FAIL reset_vs_start d%0d: busy=%b want 0", d, busy[d]);
      end
    end
    // Data offered while idle is ignored.
    Dato_in = 8'h45; In_valid = 1'b1;
    repeat (2) @(negedge Clock);
    In_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (fo[d][0] !== 7'd0 || rdy[d] !== 1'b0) begin
        failures++; $display("FAIL idle_valid d%0d: seg=%0d rdy=%b want 0/0", d, fo[d][0], rdy[d]);
      end
    end
  endtask

  task automatic test_nominal();
    load_frame(8'h45, 8'h30, 8'h13, 8'h03, 8'h21, 8'h86, 8'h16);
    send_frame(1'b0);
    for (int d = 0; d < 2; d++) begin
      for (int f = 0; f < 7; f++) begin
        checks++;
        if (fo[d][f] !== exp_f[d][f]) begin
          failures++; $display("FAIL nominal_field d%0d f%0d: got %0d want %0d", d, f, fo[d][f], exp_f[d][f]);
        end
      end
      checks++;
      if (fo[d][0] !== 7'd45 || fo[d][2] !== 7'd13 || fo[d][5] !== 7'd6 || fo[d][6] !== 7'd16) begin
        failures++; $display("FAIL nominal_literal d%0d: seg=%0d hora=%0d mes=%0d ao=%0d want 45/13/6/16",
                             d, fo[d][0], fo[d][2], fo[d][5], fo[d][6]);
      end
      checks++;
      if (cent[d] !== 1'b1 || em[d] !== 7'd0 || errf[d] !== 1'b0) begin
        failures++; $display("FAIL nominal_flags d%0d: cent=%b err=%b error=%b want 1/0/0", d, cent[d], em[d], errf[d]);
      end
      checks++;
      if (done[d] !== 1'b1 || busy[d] !== 1'b0) begin
        failures++; $display("FAIL nominal_done d%0d: done=%b busy=%b want 1/0", d, done[d], busy[d]);
      end
    end
    @(negedge Clock);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (done[d] !== 1'b0) begin
        failures++; $display("FAIL done_pulse d%0d: done=%b want 0", d, done[d]);
      end
    end
  endtask

  task automatic test_ch_bit();
    load_frame(8'hC5, 8'h30, 8'h13, 8'h03, 8'h21, 8'h86, 8'h16);
    send_frame(1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (fo[d][0] !== 7'd45 || em[d][0] !== 1'b0) begin
        failures++; $display("FAIL ch_bit d%0d: seg=%0d err0=%b want 45/0", d, fo[d][0], em[d][0]);
      end
    end
  endtask

  task automatic test_bad_fields();
    load_frame(8'h45, 8'h6A, 8'h13, 8'h03, 8'h21, 8'h13, 8'h16);
    send_frame(1'b0);
    checks++;
    if (fo[0][1] !== 7'd0 || fo[0][5] !== 7'd13) begin
      failures++; $display("FAIL bad_vals_h0: min=%0d mes=%0d want 0/13", fo[0][1], fo[0][5]);
    end
    checks++;
    if (fo[1][1] !== 7'd30 || fo[1][5] !== 7'd6) begin
      failures++; $display("FAIL bad_vals_h1: min=%0d mes=%0d want 30/6", fo[1][1], fo[1][5]);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (em[d] !== 7'b0100010 || errf[d] !== 1'b1) begin
        failures++; $display("FAIL bad_mask d%0d: err=%b error=%b want 0100010/1", d, em[d], errf[d]);
      end
    end
    // Mask must persist after Done until the next Start.
    repeat (3) @(negedge Clock);
    checks++;
    if (em[0] !== exp_err) begin
      failures++; $display("FAIL mask_hold: err=%b want %b", em[0], exp_err);
    end
  endtask

  task automatic test_12h();
    load_frame(8'h45, 8'h30, 8'h52, 8'h03, 8'h21, 8'h86, 8'h16);
    send_frame(1'b0);
    checks++;
    if (fo[0][2] !== 7'd12 || fo[1][2] !== 7'd13) begin
      failures++; $display("FAIL hour_12h: hora0=%0d hora1=%0d want 12/13", fo[0][2], fo[1][2]);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (em[d] !== exp_err || em[d][2] !== 1'b1) begin
        failures++; $display("FAIL hour_12h_mask d%0d: err=%b want %b", d, em[d], exp_err);
      end
    end
  endtask

  task automatic test_bounds();
    // Every field one step outside its range (day wraps to 0 through its mask).
    load_frame(8'h60, 8'h60, 8'h24, 8'h08, 8'h32, 8'h00, 8'h9A);
    send_frame(1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (em[d] !== 7'b1111111) begin
        failures++; $display("FAIL bounds_mask d%0d: err=%b want 1111111", d, em[d]);
      end
      for (int f = 0; f < 7; f++) begin
        checks++;
        if (fo[d][f] !== exp_f[d][f]) begin
          failures++; $display("FAIL bounds_field d%0d f%0d: got %0d want %0d", d, f, fo[d][f], exp_f[d][f]);
        end
      end
    end
  endtask

  task automatic test_stall();
    load_frame(8'h59, 8'h00, 8'h23, 8'h07, 8'h31, 8'h12, 8'h99);
    @(negedge Clock); Start = 1'b1;
    @(negedge Clock); Start = 1'b0;
    exp_err = 7'd0;
    for (int i = 0; i < 3; i++) begin
      Dato_in = frame[i]; In_valid = 1'b1;
      @(negedge Clock);
      model_byte(i, frame[i]);
    end
    In_valid = 1'b0; Dato_in = 8'h11;
    Start = 1'b1;  // must be ignored mid-frame
    repeat (5) begin
      @(negedge Clock);
      Start = 1'b0;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (busy[d] !== 1'b1 || rdy[d] !== 1'b1 || done[d] !== 1'b0 || fo[d][3] !== exp_f[d][3]) begin
          failures++; $display("FAIL stall d%0d: busy=%b rdy=%b done=%b dia=%0d want 1/1/0/%0d",
                               d, busy[d], rdy[d], done[d], fo[d][3], exp_f[d][3]);
        end
      end
    end
    for (int i = 3; i < 7; i++) begin
      Dato_in = frame[i]; In_valid = 1'b1;
      @(negedge Clock);
      model_byte(i, frame[i]);
    end
    In_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int f = 0; f < 7; f++) begin
        checks++;
        if (fo[d][f] !== exp_f[d][f]) begin
          failures++; $display("FAIL stall_field d%0d f%0d: got %0d want %0d", d, f, fo[d][f], exp_f[d][f]);
        end
      end
      checks++;
      if (em[d] !== 7'd0 || done[d] !== 1'b1) begin
        failures++; $display("FAIL stall_end d%0d: err=%b done=%b want 0/1", d, em[d], done[d]);
      end
    end
  endtask

  task automatic test_mid_reset();
    load_frame(8'h12, 8'h34, 8'h05, 8'h02, 8'h15, 8'h09, 8'h42);
    @(negedge Clock); Start = 1'b1;
    @(negedge Clock); Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Dato_in = frame[i]; In_valid = 1'b1;
      @(negedge Clock);
    end
    // Reset coincides with acceptance of field 4.
    Dato_in = frame[4]; Reset = 1'b1;
    @(negedge Clock); Reset = 1'b0; In_valid = 1'b0;
    model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int f = 0; f < 7; f++) begin
        checks++;
        if (fo[d][f] !== 7'd0) begin
          failures++; $display("FAIL midreset_field d%0d f%0d: got %0d want 0", d, f, fo[d][f]);
        end
      end
      checks++;
      if ({em[d], cent[d], busy[d], done[d], rdy[d]} !== 11'd0) begin
        failures++; $display("FAIL midreset_ctrl d%0d: err=%b cent=%b busy=%b done=%b rdy=%b want 0",
                             d, em[d], cent[d], busy[d], done[d], rdy[d]);
      end
    end
    repeat (3) begin
      @(negedge Clock);
      checks++;
      if (done[0] !== 1'b0 || done[1] !== 1'b0) begin
        failures++; $display("FAIL midreset_nodone: done=%b%b want 00", done[0], done[1]);
      end
    end
    load_frame(8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h81, 8'h00);
    send_frame(1'b0);
    for (int d = 0; d < 2; d++) begin
      for (int f = 0; f < 7; f++) begin
        checks++;
        if (fo[d][f] !== exp_f[d][f]) begin
          failures++; $display("FAIL midreset_new d%0d f%0d: got %0d want %0d", d, f, fo[d][f], exp_f[d][f]);
        end
      end
      checks++;
      if (cent[d] !== 1'b1 || em[d] !== 7'd0) begin
        failures++; $display("FAIL midreset_flags d%0d: cent=%b err=%b want 1/0", d, cent[d], em[d]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 7; i++) frame[i] = rand_byte(i);
      send_frame(1'b1);
      for (int d = 0; d < 2; d++) begin
        for (int f = 0; f < 7; f++) begin
          checks++;
          if (fo[d][f] !== exp_f[d][f]) begin
            failures++; $display("FAIL rand%0d_field d%0d f%0d byte=%h: got %0d want %0d",
                                 n, d, f, frame[f], fo[d][f], exp_f[d][f]);
          end
        end
        checks++;
        if (em[d] !== exp_err || errf[d] !== (|exp_err) || cent[d] !== exp_cent || done[d] !== 1'b1) begin
          failures++; $display("FAIL rand%0d_flags d%0d: err=%b error=%b cent=%b done=%b want %b/%b/%b/1",
                               n, d, em[d], errf[d], cent[d], done[d], exp_err, |exp_err, exp_cent);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_ch_bit();
    test_bad_fields();
    test_12h();
    test_bounds();
    test_stall();
    test_mid_reset();
    test_random();
    repeat (2) @(negedge Clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
